// File: rtl/program_loader_pkg.sv
// Shared widths, HALT opcode and FSM encoding for the program loader, the CPU
// and the instruction memory, so all three agree on word and address sizes.
package program_loader_pkg;

  localparam int unsigned INSTR_WIDTH         = 16;
  localparam int unsigned IMEM_ADDR_WIDTH     = 11;
  localparam logic [4:0]  HALT_OPCODE_DEFAULT = 5'b00000;

  typedef enum logic [1:0] {
    ST_WAIT_LO = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/program_loader_byte_pair_assembler.sv
// Holds the low/high byte registers and picks which one a UART byte lands in.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        sel_lo,
  input  logic        sel_hi,
  output logic [15:0] word
);

  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (rx_done && sel_lo) lo_d = rx_data;
    if (rx_done && sel_hi) hi_d = rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign word = {hi_q, lo_q};

endmodule

// File: rtl/program_loader.sv
// Boot loader: assembles UART byte pairs into instruction words and writes them
// to instruction memory until a HALT word is written or the memory is full.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned B           = INSTR_WIDTH,
  parameter int unsigned W           = IMEM_ADDR_WIDTH,
  parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reload,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [B-1:0] w_data,
  output logic         done,
  output logic         full,
  output logic [W:0]   word_count
);

  localparam logic [W-1:0] LAST_ADDR = '1;

  state_e       state_q, state_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         sel_lo, sel_hi;
  logic         is_halt;

  byte_pair_assembler u_bytes (
    .clk     (clk),
    .rst_n   (reset),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .sel_lo  (sel_lo),
    .sel_hi  (sel_hi),
    .word    (w_data)
  );

  assign is_halt = (w_data[B-1 -: 5] == HALT_OPCODE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    sel_lo  = 1'b0;
    sel_hi  = 1'b0;
    unique case (state_q)
      ST_WAIT_LO: begin
        sel_lo = 1'b1;
        if (rx_done) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        sel_hi = 1'b1;
        if (rx_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        count_d = count_q + (W+1)'(1);
        if (is_halt) begin
          state_d = ST_DONE;
          full_d  = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          full_d  = 1'b1;
        end else begin
          // A byte arriving during the write cycle is the next word's low byte.
          addr_d  = addr_q + W'(1);
          sel_lo  = 1'b1;
          state_d = rx_done ? ST_WAIT_HI : ST_WAIT_LO;
        end
      end
      ST_DONE: ;
      default: state_d = ST_WAIT_LO;
    endcase
    if (reload) begin
      state_d = ST_WAIT_LO;
      addr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
      sel_lo  = 1'b0;
      sel_hi  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT_LO;
      addr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign wr_en      = (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign full       = full_q;
  assign w_addr     = addr_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// loads compared against a word-list model of what memory should receive.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        reload;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        wr_en;
  logic [10:0] w_addr;
  logic [15:0] w_data;
  logic        done;
  logic        full;
  logic [11:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] mon_addr[$];
  logic [15:0] mon_data[$];

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .done       (done),
    .full       (full),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_addr.push_back(w_addr);
      mon_data.push_back(w_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic we);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    we = wr_en;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; reload = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    #12;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    n_cmp++; if (w_addr !== 11'd0) begin n_bad++; $display("FAIL reset_w_addr got=%0d exp=0", w_addr); end
    n_cmp++; if (w_data !== 16'h0) begin n_bad++; $display("FAIL reset_w_data got=%h exp=0000", w_data); end
    n_cmp++; if (done !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got done=%b full=%b exp 0/0", done, full); end
    n_cmp++; if (word_count !== 12'd0) begin n_bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    logic we;
    clear_mon();
    send_byte(8'h34, we); send_byte(8'h12, we);
    send_byte(8'h00, we); send_byte(8'h00, we);
    idle(2);
    n_cmp++; if (mon_addr.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites got=%0d exp=2", mon_addr.size()); end
    else begin
      n_cmp++; if (mon_addr[0] !== 11'd0 || mon_data[0] !== 16'h1234) begin n_bad++; $display("FAIL basic_w0 got=%h@%0d exp=1234@0", mon_data[0], mon_addr[0]); end
      n_cmp++; if (mon_addr[1] !== 11'd1 || mon_data[1] !== 16'h0000) begin n_bad++; $display("FAIL basic_w1 got=%h@%0d exp=0000@1", mon_data[1], mon_addr[1]); end
    end
    n_cmp++; if (done !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL basic_flags got done=%b full=%b exp 1/0", done, full); end
    n_cmp++; if (word_count !== 12'd2) begin n_bad++; $display("FAIL basic_word_count got=%0d exp=2", word_count); end
  endtask

  task automatic test_done_ignore();
    logic we;
    int   n0;
    n0 = mon_addr.size();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom), we);
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL done_wr_en byte=%0d got=%b exp=0", i, we); end
    end
    idle(2);
    n_cmp++; if (mon_addr.size() !== n0) begin n_bad++; $display("FAIL done_nwrites got=%0d exp=%0d", mon_addr.size(), n0); end
    n_cmp++; if (done !== 1'b1 || full !== 1'b0 || word_count !== 12'd2 || w_addr !== 11'd1)
      begin n_bad++; $display("FAIL done_frozen got done=%b full=%b wc=%0d addr=%0d exp 1/0/2/1", done, full, word_count, w_addr); end
  endtask

  task automatic test_reload();
    logic we;
    pulse_reload();
    n_cmp++; if (done !== 1'b0 || full !== 1'b0 || word_count !== 12'd0 || w_addr !== 11'd0)
      begin n_bad++; $display("FAIL reload_clear got done=%b full=%b wc=%0d addr=%0d exp 0/0/0/0", done, full, word_count, w_addr); end
    clear_mon();
    send_byte(8'hAA, we);
    rx_data = 8'hBB; rx_done = 1'b1; reload = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0; reload = 1'b0;
    send_byte(8'h78, we); send_byte(8'h56, we);
    idle(1);
    n_cmp++; if (mon_addr.size() !== 1) begin n_bad++; $display("FAIL reload_nwrites got=%0d exp=1", mon_addr.size()); end
    else begin
      n_cmp++; if (mon_addr[0] !== 11'd0 || mon_data[0] !== 16'h5678) begin n_bad++; $display("FAIL reload_w0 got=%h@%0d exp=5678@0", mon_data[0], mon_addr[0]); end
    end
    n_cmp++; if (word_count !== 12'd1 || w_addr !== 11'd1 || done !== 1'b0)
      begin n_bad++; $display("FAIL reload_after got wc=%0d addr=%0d done=%b exp 1/1/0", word_count, w_addr, done); end
    send_byte(8'h11, we); send_byte(8'h22, we);
    pulse_reload();
    n_cmp++; if (mon_addr.size() !== 2 || mon_data[$] !== 16'h2211 || mon_addr[$] !== 11'd1)
      begin n_bad++; $display("FAIL reload_in_write got n=%0d last=%h@%0d exp n=2 2211@1", mon_addr.size(), mon_data[$], mon_addr[$]); end
    n_cmp++; if (word_count !== 12'd0 || w_addr !== 11'd0)
      begin n_bad++; $display("FAIL reload_in_write_clear got wc=%0d addr=%0d exp 0/0", word_count, w_addr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3];
    logic        we;
    logic        exp_we[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pulse_reload();
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom);
      if (w[i][15:11] == 5'b00000) w[i][15:11] = 5'b00001;
    end
    for (int i = 0; i < 6; i++) begin
      send_byte((i % 2 == 0) ? w[i/2][7:0] : w[i/2][15:8], we);
      n_cmp++; if (we !== exp_we[i]) begin n_bad++; $display("FAIL b2b_wr_en byte=%0d got=%b exp=%b", i, we, exp_we[i]); end
    end
    @(negedge clk);
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL b2b_last_write got=%b exp=1", wr_en); end
    @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL b2b_single_cycle got=%b exp=0", wr_en); end
    @(posedge clk);
    #1;
    n_cmp++; if (mon_addr.size() !== 3) begin n_bad++; $display("FAIL b2b_nwrites got=%0d exp=3", mon_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (mon_addr[i] !== 11'(i) || mon_data[i] !== w[i])
          begin n_bad++; $display("FAIL b2b_word%0d got=%h@%0d exp=%h@%0d", i, mon_data[i], mon_addr[i], w[i], i); end
      end
    end
    n_cmp++; if (word_count !== 12'd3) begin n_bad++; $display("FAIL b2b_word_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_fill();
    logic we;
    logic seq_ok;
    pulse_reload();
    clear_mon();
    for (int i = 0; i < 2048; i++) begin
      send_byte(8'h01, we);
      send_byte(8'h08, we);
    end
    idle(2);
    n_cmp++; if (mon_addr.size() !== 2048) begin n_bad++; $display("FAIL fill_nwrites got=%0d exp=2048", mon_addr.size()); end
    else begin
      seq_ok = 1'b1;
      for (int i = 0; i < 2048; i++)
        if (mon_addr[i] !== 11'(i) || mon_data[i] !== 16'h0801) seq_ok = 1'b0;
      n_cmp++; if (!seq_ok) begin n_bad++; $display("FAIL fill_sequence got last=%h@%0d exp 0801@0..2047", mon_data[$], mon_addr[$]); end
    end
    n_cmp++; if (done !== 1'b1 || full !== 1'b1 || word_count !== 12'd2048 || w_addr !== 11'd2047)
      begin n_bad++; $display("FAIL fill_end got done=%b full=%b wc=%0d addr=%0d exp 1/1/2048/2047", done, full, word_count, w_addr); end
    for (int i = 0; i < 4; i++) send_byte(8'h55, we);
    idle(2);
    n_cmp++; if (mon_addr.size() !== 2048) begin n_bad++; $display("FAIL fill_no_wrap got=%0d writes exp=2048", mon_addr.size()); end
  endtask

  task automatic test_reset_mid();
    logic we;
    pulse_reload();
    clear_mon();
    send_byte(8'h9A, we);
    reset = 1'b0;
    #2;
    n_cmp++; if (wr_en !== 1'b0 || w_data !== 16'h0 || w_addr !== 11'd0 || word_count !== 12'd0 || done !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_async got we=%b data=%h addr=%0d wc=%0d done=%b exp all 0", wr_en, w_data, w_addr, word_count, done); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_byte(8'hCD, we);
    idle(2);
    n_cmp++; if (mon_addr.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_write got=%0d writes exp=0", mon_addr.size()); end
    send_byte(8'hAB, we);
    idle(1);
    n_cmp++; if (mon_addr.size() !== 1 || mon_data[0] !== 16'hABCD || mon_addr[0] !== 11'd0)
      begin n_bad++; $display("FAIL rstmid_pair got n=%0d first=%h@%0d exp n=1 ABCD@0", mon_addr.size(), mon_data[0], mon_addr[0]); end
  endtask

  task automatic test_random();
    logic [15:0] words[$];
    logic [15:0] exp_q[$];
    logic        we;
    logic        exp_done;
    int          n;
    for (int it = 0; it < 6; it++) begin
      pulse_reload();
      clear_mon();
      words.delete();
      exp_q.delete();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) == 0) v[15:11] = 5'b00000;
        else if (v[15:11] == 5'b00000) v[15:11] = 5'b11111;
        words.push_back(v);
      end
      // Memory receives every word up to and including the first HALT.
      exp_done = 1'b0;
      foreach (words[i]) begin
        if (!exp_done) begin
          exp_q.push_back(words[i]);
          if (words[i][15:11] == 5'b00000) exp_done = 1'b1;
        end
      end
      foreach (words[i]) begin
        send_byte(words[i][7:0], we);
        send_byte(words[i][15:8], we);
        idle($urandom_range(0, 2));
      end
      idle(2);
      n_cmp++; if (mon_addr.size() !== exp_q.size())
        begin n_bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", it, mon_addr.size(), exp_q.size()); end
      else begin
        foreach (exp_q[i]) begin
          n_cmp++; if (mon_addr[i] !== 11'(i) || mon_data[i] !== exp_q[i])
            begin n_bad++; $display("FAIL rand%0d_word%0d got=%h@%0d exp=%h@%0d", it, i, mon_data[i], mon_addr[i], exp_q[i], i); end
        end
      end
      n_cmp++; if (done !== exp_done || full !== 1'b0 || word_count !== 12'(exp_q.size()))
        begin n_bad++; $display("FAIL rand%0d_status got done=%b full=%b wc=%0d exp %b/0/%0d", it, done, full, word_count, exp_done, exp_q.size()); end
      n_cmp++; if (w_addr !== (exp_done ? 11'(exp_q.size() - 1) : 11'(exp_q.size())))
        begin n_bad++; $display("FAIL rand%0d_addr got=%0d", it, w_addr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_ignore();
    test_reload();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameters: B, 16, instruction width; W, 11, instruction-memory address width; HALT_OPCODE, 5'b00000, opcode in bits [B-1:B-5] that terminates a load.
REQ-002 SHALL have ports, in order: clk  in  1  single system clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 reload  in  1  synchronous one-cycle pulse that restarts loading from address 0.
REQ-005 rx_data  in  8  received byte, valid when rx_done=1.
REQ-006 rx_done  in  1  one-cycle byte strobe from the UART receiver.
REQ-007 wr_en  out  1  instruction-memory write enable.
REQ-008 w_addr  out  W  instruction-memory write address.
REQ-009 w_data  out  B  instruction-memory write data.
REQ-010 done  out  1  load finished; CPU may leave reset.
REQ-011 full  out  1  load ended because memory filled without a HALT word.
REQ-012 word_count  out  W+1  number of words written in the current load.

Function
REQ-013 SHALL assemble each instruction from two consecutive bytes, low byte first, then high byte: w_data = {hi, lo}.
REQ-014 SHALL implement FSM states WAIT_LO, WAIT_HI, WRITE and DONE.
REQ-015 WAIT_LO: rx_done latches rx_data as the low byte -> WAIT_HI.
REQ-016 WAIT_HI: rx_done latches rx_data as the high byte -> WRITE.
REQ-017 WRITE SHALL last exactly one cycle, with wr_en=1 and w_addr and w_data stable; this is the cycle after the high-byte strobe, so latency is 1 clk.
REQ-018 wr_en SHALL be 0 in every state except WRITE.
REQ-019 On leaving WRITE, word_count SHALL increment by 1.
REQ-020 On leaving WRITE, if w_data[B-1:B-5]==HALT_OPCODE -> DONE with full=0; the HALT word itself is written.
REQ-021 Else, if w_addr==2^W-1 -> DONE with full=1.
REQ-022 Else, w_addr SHALL increment by 1 and the FSM goes to WAIT_LO.
REQ-023 When HALT and the last address coincide, HALT SHALL take precedence (full=0).
REQ-024 rx_done asserted during WRITE SHALL be taken as the next low byte: the FSM goes to WAIT_HI instead of WAIT_LO, unless the exit is to DONE, where the byte is dropped.
REQ-025 DONE: done=1 SHALL be held, rx_done ignored, and w_addr, word_count and full frozen.
REQ-026 reload=1 in any state SHALL, on the next edge, force WAIT_LO, w_addr=0, word_count=0, done=0 and full=0.
REQ-027 reload SHALL have priority over rx_done in the same cycle.
REQ-028 reload during WRITE SHALL NOT suppress that cycle's write, which is already in progress.
REQ-029 w_addr SHALL never wrap; the address bound is enforced by REQ-021.

Reset
REQ-030 reset=0 SHALL asynchronously force: state=WAIT_LO, wr_en=0, w_addr=0, w_data=0, done=0, full=0, word_count=0, latched bytes=0.
REQ-031 Reset mid-load SHALL abandon any partial word; no write SHALL occur until two new bytes arrive after reset release.

Structure
REQ-032 Shared package SHALL hold B, W, HALT_OPCODE and the FSM state encoding, so the CPU and instruction memory use identical widths.
REQ-033 SHALL contain one sub-module, byte_pair_assembler, holding the lo/hi byte registers and the byte-select logic.
REQ-034 FSM, address counter and word counter SHALL stay in program_loader.

Verification
REQ-035 Bytes 34,12 then 00,00 -> writes 16'h1234@0 and 16'h0000@1; then done=1, full=0, word_count=2.
REQ-036 Stream 2048 words of 16'h0801 -> last write @2047, then done=1, full=1, word_count=2048, and no write to address 0 afterwards.
REQ-037 High-byte strobe on cycle N -> wr_en=1 only on cycle N+1; rx_done during WRITE is captured as the next low byte; 3 words are verified.
REQ-038 Pulse reload after 1 byte (mid-word) and again in DONE -> next two bytes are written @0, word_count=1.
REQ-039 Assert reset between a low and a high byte -> no write occurs; the following byte pair is written @0 with the correct {hi,lo}.
REQ-040 rx_done pulses while in DONE -> no wr_en, and outputs unchanged.
